// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter placing two cache ports onto one 2^ADDR_W x DATA_W memory with a fixed LATENCY-cycle access.
// Each completed write sends an invalidate to the other cache. A requester holds req until its ack.
module shared_mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   input  logic              i_req2,
   input  logic              i_we2,
   input  logic [ADDR_W-1:0] i_addr2,
   input  logic [DATA_W-1:0] i_wdata2,
   output logic              o_ack1,
   output logic              o_ack2,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_inv1,
   output logic              o_inv2,
   output logic [ADDR_W-1:0] o_inv_addr,
   output logic              o_busy
);
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_last;    // 0: port 1 was granted last, 1: port 2
   logic              r_port;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_ack1, r_ack2, r_inv1, r_inv2, r_busy;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_inv_addr;

   logic w_grant1, w_grant2, w_access, w_wr;

   assign w_grant2 = i_req2 & (~i_req1 | ~r_last);
   assign w_grant1 = i_req1 & ~w_grant2;
   assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
   assign w_wr     = w_access & r_we;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_last     <= 1'b1;
         r_port     <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ack1     <= 1'b0;
         r_ack2     <= 1'b0;
         r_inv1     <= 1'b0;
         r_inv2     <= 1'b0;
         r_busy     <= 1'b0;
         r_rdata    <= '0;
         r_inv_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant1 | w_grant2) begin
                  r_port  <= w_grant2;
                  r_we    <= w_grant2 ? i_we2    : i_we1;
                  r_addr  <= w_grant2 ? i_addr2  : i_addr1;
                  r_wdata <= w_grant2 ? i_wdata2 : i_wdata1;
                  r_cnt   <= CNT_INIT;
                  r_busy  <= 1'b1;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rdata <= r_we ? r_wdata : r_mem[r_addr];
                  r_ack1  <= ~r_port;
                  r_ack2  <= r_port;
                  // the writer never invalidates itself
                  r_inv1  <= r_we & r_port;
                  r_inv2  <= r_we & ~r_port;
                  if (r_we) r_inv_addr <= r_addr;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_ack1  <= 1'b0;
               r_ack2  <= 1'b0;
               r_inv1  <= 1'b0;
               r_inv2  <= 1'b0;
               r_busy  <= 1'b0;
               r_last  <= r_port;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Reset restores the identity image, so an aborted write leaves no trace.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(i);
      end else if (w_wr) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign o_ack1     = r_ack1;
   assign o_ack2     = r_ack2;
   assign o_rdata    = r_rdata;
   assign o_inv1     = r_inv1;
   assign o_inv2     = r_inv2;
   assign o_inv_addr = r_inv_addr;
   assign o_busy     = r_busy;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a LATENCY=4 instance for most scenarios and a LATENCY=1 instance.
module tb_shared_mem_arbiter;
   logic       clk, rst_n;
   logic       req1, we1, req2, we2;
   logic [7:0] addr1, wdata1, addr2, wdata2;
   logic       ack1, ack2, inv1, inv2, busy;
   logic [7:0] rdata, inv_addr;

   logic       req1_b, we1_b, req2_b, we2_b;
   logic [7:0] addr1_b, wdata1_b, addr2_b, wdata2_b;
   logic       ack1_b, ack2_b, inv1_b, inv2_b, busy_b;
   logic [7:0] rdata_b, inv_addr_b;

   int n_tests = 0;
   int n_fail  = 0;

   int         k_ack1, k_ack2, k_inv1, k_inv2, k_busy;
   int         n_ack1, n_ack2, n_inv1, n_inv2;
   logic [7:0] d_ack1, d_ack2, a_inv;
   int         grants[$];
   int         rearm1 = 0, rearm2 = 0;

   shared_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(4)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
      .i_req2(req2), .i_we2(we2), .i_addr2(addr2), .i_wdata2(wdata2),
      .o_ack1(ack1), .o_ack2(ack2), .o_rdata(rdata),
      .o_inv1(inv1), .o_inv2(inv2), .o_inv_addr(inv_addr), .o_busy(busy)
   );

   shared_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut_l1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req1(req1_b), .i_we1(we1_b), .i_addr1(addr1_b), .i_wdata1(wdata1_b),
      .i_req2(req2_b), .i_we2(we2_b), .i_addr2(addr2_b), .i_wdata2(wdata2_b),
      .o_ack1(ack1_b), .o_ack2(ack2_b), .o_rdata(rdata_b),
      .o_inv1(inv1_b), .o_inv2(inv2_b), .o_inv_addr(inv_addr_b), .o_busy(busy_b)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req1 = 0; req2 = 0; we1 = 0; we2 = 0;
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      step();
   endtask

   // Steps ncyc edges on the LATENCY=4 instance, logging acks/invalidates and
   // dropping each req after its ack (re-raising it next cycle while rearm lasts).
   task automatic observe(input int ncyc);
      bit p1, p2;
      p1 = 0; p2 = 0;
      k_ack1 = 0; k_ack2 = 0; k_inv1 = 0; k_inv2 = 0; k_busy = 0;
      n_ack1 = 0; n_ack2 = 0; n_inv1 = 0; n_inv2 = 0;
      d_ack1 = 0; d_ack2 = 0; a_inv = 0;
      grants.delete();
      for (int k = 1; k <= ncyc; k++) begin
         step();
         if (p1) begin req1 = 1; p1 = 0; end
         if (p2) begin req2 = 1; p2 = 0; end
         if (busy && k_busy == 0) k_busy = k;
         if (ack1) begin
            n_ack1++; k_ack1 = k; d_ack1 = rdata; grants.push_back(1); req1 = 0;
            if (rearm1 > 0) begin rearm1--; p1 = 1; end
         end
         if (ack2) begin
            n_ack2++; k_ack2 = k; d_ack2 = rdata; grants.push_back(2); req2 = 0;
            if (rearm2 > 0) begin rearm2--; p2 = 1; end
         end
         if (inv1) begin n_inv1++; k_inv1 = k; a_inv = inv_addr; end
         if (inv2) begin n_inv2++; k_inv2 = k; a_inv = inv_addr; end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      #1;
      step();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_tests++; if ({ack1, ack2} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {ack1, ack2}); end
      n_tests++; if ({inv1, inv2} !== 2'b00) begin n_fail++; $display("FAIL reset_inv: got %b expected 00", {inv1, inv2}); end
      n_tests++; if (rdata !== 8'd0) begin n_fail++; $display("FAIL reset_rdata: got %0d expected 0", rdata); end
      n_tests++; if (inv_addr !== 8'd0) begin n_fail++; $display("FAIL reset_inv_addr: got %0d expected 0", inv_addr); end
      rst_n = 1;
      observe(4);
      n_tests++; if (k_busy !== 0) begin n_fail++; $display("FAIL idle_busy: got busy at cycle %0d expected never", k_busy); end
   endtask

   task automatic test_single_read();
      req1 = 1; we1 = 0; addr1 = 8'd1;
      observe(8);
      n_tests++; if (k_busy !== 1) begin n_fail++; $display("FAIL read_busy_cycle: got %0d expected 1", k_busy); end
      n_tests++; if (n_ack1 !== 1) begin n_fail++; $display("FAIL read_ack1_count: got %0d expected 1", n_ack1); end
      n_tests++; if (k_ack1 !== 5) begin n_fail++; $display("FAIL read_ack1_cycle: got %0d expected 5", k_ack1); end
      n_tests++; if (d_ack1 !== 8'd1) begin n_fail++; $display("FAIL read_rdata: got %0d expected 1", d_ack1); end
      n_tests++; if (n_ack2 !== 0) begin n_fail++; $display("FAIL read_ack2_count: got %0d expected 0", n_ack2); end
      n_tests++; if (n_inv1 + n_inv2 !== 0) begin n_fail++; $display("FAIL read_inv_count: got %0d expected 0", n_inv1 + n_inv2); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after: got %0b expected 0", busy); end
   endtask

   task automatic test_contention();
      apply_reset();
      req1 = 1; we1 = 0; addr1 = 8'd4;
      req2 = 1; we2 = 1; addr2 = 8'd1; wdata2 = 8'd99;
      observe(14);
      n_tests++; if (k_ack1 !== 5) begin n_fail++; $display("FAIL cont_ack1_cycle: got %0d expected 5", k_ack1); end
      n_tests++; if (d_ack1 !== 8'd4) begin n_fail++; $display("FAIL cont_rdata1: got %0d expected 4", d_ack1); end
      n_tests++; if (k_ack2 !== 11) begin n_fail++; $display("FAIL cont_ack2_cycle: got %0d expected 11", k_ack2); end
      n_tests++; if (d_ack2 !== 8'd99) begin n_fail++; $display("FAIL cont_rdata2: got %0d expected 99", d_ack2); end
      n_tests++; if (n_inv1 !== 1 || k_inv1 !== 11) begin n_fail++; $display("FAIL cont_inv1: got count %0d cycle %0d expected count 1 cycle 11", n_inv1, k_inv1); end
      n_tests++; if (n_inv2 !== 0) begin n_fail++; $display("FAIL cont_inv2_count: got %0d expected 0", n_inv2); end
      n_tests++; if (a_inv !== 8'd1) begin n_fail++; $display("FAIL cont_inv_addr: got %0d expected 1", a_inv); end
      we2 = 0;
      req1 = 1; we1 = 0; addr1 = 8'd1;
      observe(8);
      n_tests++; if (n_ack1 !== 1 || d_ack1 !== 8'd99) begin n_fail++; $display("FAIL cont_readback: got count %0d data %0d expected count 1 data 99", n_ack1, d_ack1); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      rearm1 = 2; rearm2 = 2;
      req1 = 1; we1 = 0; addr1 = 8'd10;
      req2 = 1; we2 = 0; addr2 = 8'd20;
      observe(40);
      n_tests++; if (grants.size() !== 6) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 6", grants.size()); end
      for (int i = 0; i < grants.size() && i < 6; i++) begin
         n_tests++;
         if (grants[i] !== ((i % 2 == 0) ? 1 : 2)) begin
            n_fail++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, grants[i], (i % 2 == 0) ? 1 : 2);
         end
      end
      n_tests++; if (k_ack2 !== 35) begin n_fail++; $display("FAIL rr_last_ack_cycle: got %0d expected 35", k_ack2); end
      rearm1 = 0; rearm2 = 0;
   endtask

   task automatic test_freeze();
      req1 = 1; we1 = 0; addr1 = 8'd5;
      step();
      addr1 = 8'd9;
      observe(8);
      n_tests++; if (n_ack1 !== 1 || k_ack1 !== 4) begin n_fail++; $display("FAIL freeze_ack: got count %0d cycle %0d expected count 1 cycle 4", n_ack1, k_ack1); end
      n_tests++; if (d_ack1 !== 8'd5) begin n_fail++; $display("FAIL freeze_read_rdata: got %0d expected 5", d_ack1); end
      req1 = 1; we1 = 1; addr1 = 8'd12; wdata1 = 8'd33;
      step();
      addr1 = 8'd13; wdata1 = 8'd44; we1 = 0;
      observe(8);
      n_tests++; if (d_ack1 !== 8'd33) begin n_fail++; $display("FAIL freeze_write_rdata: got %0d expected 33", d_ack1); end
      n_tests++; if (n_inv2 !== 1 || n_inv1 !== 0 || a_inv !== 8'd12) begin n_fail++; $display("FAIL freeze_inv: got inv2 %0d inv1 %0d addr %0d expected 1 0 12", n_inv2, n_inv1, a_inv); end
      req1 = 1; we1 = 0; addr1 = 8'd12;
      observe(8);
      n_tests++; if (d_ack1 !== 8'd33) begin n_fail++; $display("FAIL freeze_readback12: got %0d expected 33", d_ack1); end
      req1 = 1; we1 = 0; addr1 = 8'd13;
      observe(8);
      n_tests++; if (d_ack1 !== 8'd13) begin n_fail++; $display("FAIL freeze_readback13: got %0d expected 13", d_ack1); end
   endtask

   task automatic test_reset_abort();
      apply_reset();
      req2 = 1; we2 = 1; addr2 = 8'd3; wdata2 = 8'd77;
      step();
      step();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %0b expected 1", busy); end
      rst_n = 0;
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_in_reset: got %0b expected 0", busy); end
      req2 = 0; we2 = 0;
      step();
      rst_n = 1;
      observe(8);
      n_tests++; if (n_ack2 !== 0 || n_inv1 !== 0) begin n_fail++; $display("FAIL abort_no_ack_inv: got ack2 %0d inv1 %0d expected 0 0", n_ack2, n_inv1); end
      req1 = 1; we1 = 0; addr1 = 8'd3;
      observe(8);
      n_tests++; if (n_ack1 !== 1 || d_ack1 !== 8'd3) begin n_fail++; $display("FAIL abort_readback: got count %0d data %0d expected count 1 data 3", n_ack1, d_ack1); end
   endtask

   task automatic test_latency1();
      int k_a, n_a, n_i2, n_i1;
      logic [7:0] d_a, a_i;
      k_a = 0; n_a = 0; d_a = 0;
      req1_b = 1; we1_b = 0; addr1_b = 8'd200;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (ack1_b) begin n_a++; k_a = k; d_a = rdata_b; req1_b = 0; end
      end
      n_tests++; if (n_a !== 1 || k_a !== 2) begin n_fail++; $display("FAIL l1_read_ack: got count %0d cycle %0d expected count 1 cycle 2", n_a, k_a); end
      n_tests++; if (d_a !== 8'd200) begin n_fail++; $display("FAIL l1_read_rdata: got %0d expected 200", d_a); end
      k_a = 0; n_a = 0; n_i1 = 0; n_i2 = 0; a_i = 0;
      req1_b = 1; we1_b = 1; addr1_b = 8'd7; wdata1_b = 8'd55;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (inv2_b) begin n_i2++; a_i = inv_addr_b; end
         if (inv1_b) n_i1++;
         if (ack1_b) begin n_a++; k_a = k; req1_b = 0; we1_b = 0; end
      end
      n_tests++; if (n_a !== 1 || k_a !== 2) begin n_fail++; $display("FAIL l1_write_ack: got count %0d cycle %0d expected count 1 cycle 2", n_a, k_a); end
      n_tests++; if (n_i2 !== 1 || n_i1 !== 0 || a_i !== 8'd7) begin n_fail++; $display("FAIL l1_write_inv: got inv2 %0d inv1 %0d addr %0d expected 1 0 7", n_i2, n_i1, a_i); end
      n_a = 0; d_a = 0;
      req2_b = 1; we2_b = 0; addr2_b = 8'd7;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (ack2_b) begin n_a++; d_a = rdata_b; req2_b = 0; end
      end
      n_tests++; if (n_a !== 1 || d_a !== 8'd55) begin n_fail++; $display("FAIL l1_readback: got count %0d data %0d expected count 1 data 55", n_a, d_a); end
   endtask

   initial begin
      rst_n = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
      req1_b = 0; we1_b = 0; addr1_b = 0; wdata1_b = 0;
      req2_b = 0; we2_b = 0; addr2_b = 0; wdata2_b = 0;
      test_reset();
      test_single_read();
      test_contention();
      test_round_robin();
      test_freeze();
      test_reset_abort();
      test_latency1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Shared main-memory stage that sits directly below the two cache controllers of the dual-processor cache system. It accepts miss-fill reads and write-through writes from both controllers and arbitrates them round-robin onto a single internal 256×8 main memory with a fixed multi-cycle access latency. It returns read data and acknowledges each request. On every completed write it broadcasts a snoop invalidate to the *other* cache.

## Interface
- ADDR_W, 8, address width; memory depth is 2^ADDR_W
- DATA_W, 8, data width
- LATENCY, 4, memory access cycles, legal range 1..15

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req1 / req2  in  1  request from cache 1 / 2; held high until its ack is seen
- we1 / we2  in  1  1 = write, 0 = read; qualified by req
- addr1 / addr2  in  ADDR_W  request address
- wdata1 / wdata2  in  DATA_W  write data
- ack1 / ack2  out  1  one-cycle completion pulse to cache 1 / 2
- rdata  out  DATA_W  read data, or the written data for writes; valid while an ack is high
- inv1 / inv2  out  1  one-cycle snoop-invalidate to cache 1 / 2
- inv_addr  out  ADDR_W  address being invalidated; valid while inv1 or inv2 is high
- busy  out  1  high in BUSY and DONE states

## Operation
- FSM has three states:
  - IDLE: sample req1 and req2.
    - Neither high: stay in IDLE.
    - One high: grant that port.
    - Both high: grant the port not granted last.
    - On a grant, latch port id, we, addr and wdata, load cnt = LATENCY-1, go to BUSY.
  - BUSY: while cnt ≠ 0, decrement cnt. When cnt = 0, perform the access and go to DONE.
    - Write: mem[addr] ← wdata and rdata ← wdata.
    - Read: rdata ← mem[addr].
  - DONE: ack of the granted port is high for exactly this cycle.
    - Write: inv of the other port is also high and inv_addr = latched addr.
    - Update last_grant, then go to IDLE.
- Round-robin state is last_grant, which resets to port 2, so port 1 wins the first contention.
- Latched fields are frozen for the whole transaction. Changes on addr, we or wdata after the grant are ignored.
- A request from the non-granted port stays pending; it is not lost.
- A requester must drop req on the clock edge that ends its DONE cycle. The IDLE state that follows therefore never re-grants a stale request.
- No invalidate is generated for reads.
- There is never an invalidate to the writing port itself.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state = IDLE, cnt = 0, last_grant = 2
  - ack1 = ack2 = inv1 = inv2 = busy = 0
  - rdata = 0, inv_addr = 0
  - memory initialised to mem[i] = i
- Reset asserted mid-transaction aborts it:
  - no ack, no inv
  - a pending write is discarded
  - memory returns to its initial image
- Latency: req is sampled at edge E0, which moves to BUSY. The access happens at edge E0+LATENCY. ack is high during the cycle after edge E0+LATENCY. IDLE is re-entered at edge E0+LATENCY+1.
- Minimum request-to-request spacing from one port is LATENCY+2 cycles. Back-to-back alternating grants under full contention also take LATENCY+2 cycles each.
- Outputs are registered and there is no combinational path from inputs to outputs.
- Simultaneous req1 and req2 with identical addresses are serialised; the second access sees the result of the first.

## Test plan
- Reset, then req1 read at addr 1 (LATENCY = 4): busy rises 1 cycle after the sampling edge, ack1 pulses once 5 cycles after it, rdata = 1, no inv, ack2 stays 0.
- Both ports request in the same cycle after reset (port 1 reads addr 4, port 2 writes 99 to addr 1):
  - port 1 is granted first; ack1 returns rdata = 4
  - port 2 is granted 6 cycles later; ack2 returns rdata = 99 with inv1 high and inv_addr = 1
  - a following port 1 read of addr 1 returns 99
- Contention repeated 3 times with both reqs held (re-asserted after each ack): grants alternate 1, 2, 1, 2, 1, 2 with no starvation.
- Port 1 changes addr1 from 5 to 9 during BUSY: the ack returns mem[5] = 5.
- Reset pulsed during BUSY of a port 2 write of 77 to addr 3: no ack2 and no inv1; after reset a read of addr 3 returns 3.
- LATENCY = 1 build: read of addr 200 acks 2 cycles after sampling with rdata = 200.
